// File: rtl/sigma_delta_sample_sequencer.sv
// Paces signed audio samples into a sigma-delta DAC: FIFO, tick, underflow hold, soft mute.
// Option: define SIGMA_DELTA_SEQ_INTERP_EN for linear interpolation between samples.
module sigma_delta_sample_sequencer #(
  parameter int signalwidth = 16,
  parameter int RATE_SHIFT  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int MUTE_SHIFT  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   mute,
  input  logic [signalwidth-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [signalwidth-1:0] d_out,
  output logic                   tick,
  output logic                   underflow,
  output logic                   muted
);

  localparam int W  = signalwidth;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [W:0] STEP =
    signed'((W+1)'(1) << MUTE_SHIFT);

  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_MUTING,
    S_MUTED
  } state_t;

  state_t                r_state;
  logic [W-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_cnt;
  logic [RATE_SHIFT-1:0] r_ctr;
  logic [W-1:0]          r_dout;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_pop;
  logic [W-1:0]          w_head;
  logic signed [W:0]     w_dx;
  logic signed [W:0]     w_ramp;

  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_tick  = (r_state != S_OFF) && (&r_ctr);
  assign w_push  = s_valid && s_ready;
  assign w_pop   = enable && w_tick && !w_empty;
  assign w_head  = r_mem[r_rp];

  assign s_ready   = enable && !w_full;
  assign d_out     = r_dout;
  assign tick      = w_tick;
  assign muted     = (r_state == S_MUTED);
  assign underflow = enable && w_tick && w_empty
                  && !mute && (r_state == S_RUN);

  // One extra bit so the most negative code can step up without wrapping
  assign w_dx = signed'({r_dout[W-1], r_dout});

  always_comb begin
    w_ramp = '0;
    if (w_dx > STEP) begin
      w_ramp = w_dx - STEP;
    end else if (w_dx < -STEP) begin
      w_ramp = w_dx + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (!enable) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_cnt <= r_cnt + (AW+1)'(w_push)
                     - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctr <= '0;
    end else if (!enable || r_state == S_OFF) begin
      r_ctr <= '0;
    end else begin
      r_ctr <= r_ctr + RATE_SHIFT'(1);
    end
  end

`ifdef SIGMA_DELTA_SEQ_INTERP_EN
  localparam int AC = W + RATE_SHIFT + 1;

  logic signed [W-1:0]  r_tgt;
  logic signed [W:0]    r_delta;
  logic signed [AC-1:0] r_acc;
  logic [W-1:0]         w_tgt_nx;
  logic signed [AC-1:0] w_acc_nx;
  logic [W-1:0]         w_acc_dout;
  logic                 w_step_en;

  assign w_tgt_nx   = w_empty ? r_tgt : w_head;
  assign w_acc_nx   = w_tick ? (AC'(r_tgt) <<< RATE_SHIFT)
                             : (r_acc + AC'(r_delta));
  assign w_acc_dout = w_acc_nx[RATE_SHIFT +: W];
  assign w_step_en  = !mute && (r_state == S_RUN
                   || (r_state == S_MUTED && w_tick));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tgt   <= '0;
      r_delta <= '0;
      r_acc   <= '0;
    end else if (!enable) begin
      r_tgt   <= '0;
      r_delta <= '0;
      r_acc   <= '0;
    end else if (w_step_en) begin
      r_acc <= w_acc_nx;
      if (w_tick) begin
        r_tgt   <= w_tgt_nx;
        r_delta <= signed'({w_tgt_nx[W-1], w_tgt_nx})
                 - signed'({r_tgt[W-1], r_tgt});
      end
    end else if (r_state == S_MUTED) begin
      r_tgt   <= '0;
      r_delta <= '0;
      r_acc   <= '0;
    end else begin
      r_acc <= AC'(signed'(r_dout)) <<< RATE_SHIFT;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_OFF;
      r_dout  <= '0;
    end else if (!enable) begin
      r_state <= S_OFF;
      r_dout  <= '0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (mute) begin
            r_state <= S_MUTING;
          end else begin
`ifdef SIGMA_DELTA_SEQ_INTERP_EN
            r_dout <= w_acc_dout;
`else
            if (w_tick && !w_empty) begin
              r_dout <= w_head;
            end
`endif
          end
        end
        S_MUTING: begin
          r_dout <= w_ramp[W-1:0];
          if (w_ramp == '0) begin
            r_state <= S_MUTED;
          end
        end
        S_MUTED: begin
          r_dout <= '0;
          if (!mute && w_tick) begin
            r_state <= S_RUN;
`ifndef SIGMA_DELTA_SEQ_INTERP_EN
            if (!w_empty) begin
              r_dout <= w_head;
            end
`endif
          end
        end
        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_delta_sample_sequencer.sv
// Scoreboard bench for sigma_delta_sample_sequencer (default build, no interpolation).
module tb_sigma_delta_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        mute;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] d_out;
  logic        tick;
  logic        underflow;
  logic        muted;

  int          passed = 0;
  int          total  = 0;
  logic [15:0] expq[$];
  logic [15:0] ev;

  always #5 clk = ~clk;

  sigma_delta_sample_sequencer #(
    .signalwidth(16),
    .RATE_SHIFT (4),
    .FIFO_DEPTH (4),
    .MUTE_SHIFT (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .mute     (mute),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .d_out    (d_out),
    .tick     (tick),
    .underflow(underflow),
    .muted    (muted)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1);
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    s_data  = v;
    s_valid = 1'b1;
    clk_step();
    s_valid = 1'b0;
    expq.push_back(v);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 40) begin
      clk_step();
      n++;
    end
    total++;
    if (tick !== 1'b1)
      $display("FAIL tick_timeout: tick=%b after %0d clk, required 1", tick, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; mute = 1'b0;
    s_valid = 1'b0; s_data = '0;
    clk_step(); clk_step();
    total++; if (d_out !== 16'h0) $display("FAIL rst_dout: got %h required 0000", d_out); else passed++;
    total++; if (s_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", s_ready); else passed++;
    total++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b required 0", tick); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL rst_uflow: got %b required 0", underflow); else passed++;
    total++; if (muted !== 1'b0) $display("FAIL rst_muted: got %b required 0", muted); else passed++;
    reset_n = 1'b1;
    clk_step(); clk_step();
    total++; if (tick !== 1'b0) $display("FAIL off_tick: got %b required 0", tick); else passed++;
  endtask

  task automatic test_basic();
    int k;
    enable = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) $display("FAIL en_ready: got %b required 1", s_ready); else passed++;
    push(16'h1000);
    push(16'h2000);
    wait_tick(k);
    total++; if (k + 2 != 16) $display("FAIL first_tick: got %0d clk required 16", k + 2); else passed++;
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL load1: got %h required %h", d_out, ev); else passed++;
    total++; if (tick !== 1'b0) $display("FAIL tick_pulse: got %b required 0", tick); else passed++;
    wait_tick(k);
    total++; if (k + 1 != 16) $display("FAIL tick_period: got %0d required 16", k + 1); else passed++;
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL load2: got %h required %h", d_out, ev); else passed++;
  endtask

  task automatic test_underflow();
    int k;
    wait_tick(k);
    total++; if (underflow !== 1'b1) $display("FAIL uflow_hi: got %b required 1", underflow); else passed++;
    clk_step();
    total++; if (underflow !== 1'b0) $display("FAIL uflow_pulse: got %b required 0", underflow); else passed++;
    total++; if (d_out !== 16'h2000) $display("FAIL uflow_hold: got %h required 2000", d_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int k;
    for (int i = 0; i < 5; i++) begin
      s_data  = 16'h3000 + 16'(i * 256);
      s_valid = 1'b1;
      total++;
      if (s_ready !== (i < 4))
        $display("FAIL bp_ready%0d: got %b required %b", i, s_ready, i < 4);
      else passed++;
      clk_step();
      if (i < 4) expq.push_back(s_data);
    end
    wait_tick(k);
    total++; if (s_ready !== 1'b0) $display("FAIL bp_full: got %b required 0", s_ready); else passed++;
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL bp_pop: got %h required %h", d_out, ev); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL bp_free: got %b required 1", s_ready); else passed++;
    clk_step();
    expq.push_back(s_data);
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(k);
      clk_step();
      ev = expq.pop_front();
      total++;
      if (d_out !== ev) $display("FAIL bp_drain%0d: got %h required %h", i, d_out, ev);
      else passed++;
    end
  endtask

  task automatic test_mute();
    int k;
    push(16'h0300);
    wait_tick(k);
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL m_load: got %h required %h", d_out, ev); else passed++;
    mute = 1'b1;
    clk_step();
    total++; if (d_out !== 16'h0300) $display("FAIL m_enter: got %h required 0300", d_out); else passed++;
    clk_step();
    total++; if (d_out !== 16'h0200) $display("FAIL m_r1: got %h required 0200", d_out); else passed++;
    clk_step();
    total++; if (d_out !== 16'h0100) $display("FAIL m_r2: got %h required 0100", d_out); else passed++;
    total++; if (muted !== 1'b0) $display("FAIL m_early: got %b required 0", muted); else passed++;
    clk_step();
    total++; if (d_out !== 16'h0000) $display("FAIL m_r3: got %h required 0000", d_out); else passed++;
    total++; if (muted !== 1'b1) $display("FAIL m_muted: got %b required 1", muted); else passed++;
    push(16'h0B00);
    wait_tick(k);
    clk_step();
    void'(expq.pop_front());
    total++; if (d_out !== 16'h0000) $display("FAIL m_discard: got %h required 0000", d_out); else passed++;
    mute = 1'b0;
    push(16'h0A00);
    wait_tick(k);
    total++; if (muted !== 1'b1) $display("FAIL m_wait: got %b required 1", muted); else passed++;
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL m_resume: got %h required %h", d_out, ev); else passed++;
    total++; if (muted !== 1'b0) $display("FAIL m_unmuted: got %b required 0", muted); else passed++;
  endtask

  task automatic test_full_ramp(input logic [15:0] v);
    int k;
    int e;
    if (muted === 1'b1) begin
      mute = 1'b0;
      wait_tick(k);
      clk_step();
    end
    push(v);
    wait_tick(k);
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL fr_load: got %h required %h", d_out, ev); else passed++;
    mute = 1'b1;
    clk_step();
    e = int'($signed(v));
    for (int i = 0; i < 200 && e != 0; i++) begin
      if (e > 256) e = e - 256;
      else if (e < -256) e = e + 256;
      else e = 0;
      clk_step();
      total++;
      if (d_out !== 16'(e) || underflow !== 1'b0)
        $display("FAIL ramp%0d: got %h/%b required %h/0", i, d_out, underflow, 16'(e));
      else passed++;
    end
    total++; if (muted !== 1'b1) $display("FAIL fr_muted: got %b required 1", muted); else passed++;
  endtask

  task automatic test_disable();
    int k;
    mute = 1'b0;
    wait_tick(k);
    clk_step();
    push(16'h6000);
    push(16'h1111);
    push(16'h2222);
    wait_tick(k);
    clk_step();
    ev = expq.pop_front();
    total++; if (d_out !== ev) $display("FAIL d_load: got %h required %h", d_out, ev); else passed++;
    mute = 1'b1;
    clk_step();
    clk_step();
    total++; if (d_out !== 16'h5F00) $display("FAIL d_ramp: got %h required 5f00", d_out); else passed++;
    enable = 1'b0;
    mute   = 1'b0;
    #1;
    total++; if (s_ready !== 1'b0) $display("FAIL d_ready: got %b required 0", s_ready); else passed++;
    clk_step();
    expq.delete();
    total++; if (d_out !== 16'h0) $display("FAIL d_zero: got %h required 0000", d_out); else passed++;
    total++; if (muted !== 1'b0) $display("FAIL d_muted: got %b required 0", muted); else passed++;
    total++; if (tick !== 1'b0) $display("FAIL d_tick: got %b required 0", tick); else passed++;
    enable = 1'b1;
    clk_step();
    wait_tick(k);
    total++; if (k != 15) $display("FAIL d_restart: got %0d required 15", k); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL d_flushed: got %b required 1", underflow); else passed++;
    clk_step();
    total++; if (d_out !== 16'h0) $display("FAIL d_hold0: got %h required 0000", d_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_mute();
    test_full_ramp(16'h8000);
    test_full_ramp(16'h7FFF);
    test_disable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
